spi_regbank_burst: RTL and testbench

Parametrised SPI slave register bank that succeeds the fixed 149-byte SPI configuration interface. It decodes an instruction, a 16-bit address and a burst of data bytes with auto-increment. It drives N_READY independently settable/clearable ready flags and exposes the whole bank flat to the SNN core. It sits between the chip SPI pins and the network configuration inputs (decay, threshold, weights, delays, debug config).

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_regbank_burst_shifter.sv | 38 +++
 rtl/spi_regbank_burst.sv | 131 +++++++++++++
 tb/tb_spi_regbank_burst.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: opcodes, FSM states and the SNN configuration address map shared by the SPI register bank
package spi_pkg;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_SET_BASE = 8'h10;
  localparam logic [7:0] OP_CLR_BASE = 8'h20;
  localparam int ADDR_DECAY = 0;
  localparam int ADDR_REFR = 1;
  localparam int ADDR_THR = 2;
  localparam int ADDR_DIV = 3;
  localparam int ADDR_W_BASE = 4;
  localparam int ADDR_D_BASE = 52;
  localparam int ADDR_DBG = 148;
  typedef enum logic [2:0] {IDLE, INSTR, ADDR_H, ADDR_L, DATA, WAIT} spi_state_t;
endpackage

// File: rtl/spi_regbank_burst_shifter.sv
// spi_byte_shifter: bit counter, MOSI shift-in, byte-valid pulse and (under SPI_READBACK_EN) MISO shift-out
module spi_byte_shifter (
  input logic SCLK,
  input logic RESET_N,
  input logic SS,
  input logic MOSI,
`ifdef SPI_READBACK_EN
  input logic load,
  input logic [7:0] load_byte,
  output logic MISO,
`endif
  output logic byte_done,
  output logic [7:0] rx_byte,
  output logic data_valid_out
);
  logic [2:0] cnt;
  logic [6:0] sr;
  assign byte_done = !SS && cnt == 3'd7;
  assign rx_byte = {sr, MOSI};
  always_ff @(posedge SCLK)
    if (!RESET_N || SS) begin
      cnt <= '0;
      sr <= '0;
      data_valid_out <= 1'b0;
    end else begin
      cnt <= cnt + 3'd1;
      sr <= rx_byte[6:0];
      data_valid_out <= byte_done;
    end
`ifdef SPI_READBACK_EN
  logic [7:0] tx;
  assign MISO = tx[7];
  always_ff @(posedge SCLK)
    if (!RESET_N || SS) tx <= '0;
    else tx <= load ? load_byte : {tx[6:0], 1'b0};
`else
`endif
endmodule

// File: rtl/spi_regbank_burst.sv
// spi_regbank_burst: SPI slave byte bank with burst auto-increment and ready flags; READ path only under SPI_READBACK_EN
module spi_regbank_burst
  import spi_pkg::*;
#(
  parameter int DEPTH = 149,
  parameter int ADDR_W = 16,
  parameter int N_READY = 2
) (
  input logic SCLK,
  input logic RESET_N,
  input logic SS,
  input logic MOSI,
  output logic MISO,
  output logic [DEPTH*8-1:0] all_data_out,
  output logic [N_READY-1:0] ready_flags,
  output logic spi_instruction_done,
  output logic data_valid_out,
  output logic addr_err
);
  spi_state_t state, state_n;
  logic byte_done, rd_op, rd_err, in_rng, is_set, is_clr, is_mem;
  logic idone, wr_go, fl_go, err_go, wr_en, fl_en, fl_set;
  logic [7:0] rx_byte, addr_h, wr_data;
  logic [15:0] frame_addr;
  logic [ADDR_W-1:0] addr, addr_new, addr_inc, wr_addr;
  logic [N_READY-1:0] fl_mask;
  assign frame_addr = {addr_h, rx_byte};
  assign addr_new = frame_addr[ADDR_W-1:0];
  assign in_rng = 32'(addr) < DEPTH;
  // out-of-range addresses stay put so a burst never wanders back into the bank
  assign addr_inc = !in_rng ? addr : (32'(addr) == DEPTH - 1) ? '0 : addr + ADDR_W'(1);
  assign is_set = rx_byte[7:4] == OP_SET_BASE[7:4] && 32'(rx_byte[3:0]) < N_READY;
  assign is_clr = rx_byte[7:4] == OP_CLR_BASE[7:4] && 32'(rx_byte[3:0]) < N_READY;
`ifdef SPI_READBACK_EN
  logic load;
  logic [7:0] rd_data;
  logic [ADDR_W-1:0] ld_addr;
  assign is_mem = rx_byte == OP_WRITE || rx_byte == OP_READ;
  assign ld_addr = state == ADDR_L ? addr_new : addr_inc;
  assign load = byte_done && rd_op && (state == ADDR_L || state == DATA);
  assign rd_err = load && 32'(ld_addr) >= DEPTH;
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) if (32'(ld_addr) == i) rd_data = all_data_out[i*8 +: 8];
  end
  always_ff @(posedge SCLK)
    if (!RESET_N) rd_op <= 1'b0;
    else if (byte_done && state == INSTR) rd_op <= rx_byte == OP_READ;
`else
  assign is_mem = rx_byte == OP_WRITE;
  assign rd_op = 1'b0;
  assign rd_err = 1'b0;
  assign MISO = 1'b0;
`endif
  spi_byte_shifter u_shift (
    .SCLK(SCLK),
    .RESET_N(RESET_N),
    .SS(SS),
    .MOSI(MOSI),
`ifdef SPI_READBACK_EN
    .load(load),
    .load_byte(rd_data),
    .MISO(MISO),
`endif
    .byte_done(byte_done),
    .rx_byte(rx_byte),
    .data_valid_out(data_valid_out)
  );
  always_ff @(posedge SCLK) state <= !RESET_N ? IDLE : state_n;
  always_comb begin
    state_n = state;
    idone = 1'b0;
    wr_go = 1'b0;
    fl_go = 1'b0;
    err_go = 1'b0;
    if (SS) state_n = IDLE;
    else if (state == IDLE) state_n = INSTR;
    else if (byte_done)
      case (state)
        INSTR: begin
          state_n = is_mem ? ADDR_H : WAIT;
          idone = !is_mem;
          fl_go = is_set || is_clr;
        end
        ADDR_H: state_n = ADDR_L;
        ADDR_L: begin
          state_n = DATA;
          idone = 1'b1;
        end
        DATA: begin
          wr_go = !rd_op && in_rng;
          err_go = !rd_op && !in_rng;
        end
        default: ;
      endcase
  end
  // writes and flag updates land one edge after the byte completes
  always_ff @(posedge SCLK)
    if (!RESET_N) begin
      addr_h <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      fl_en <= 1'b0;
      fl_set <= 1'b0;
      fl_mask <= '0;
      ready_flags <= '0;
      addr_err <= 1'b0;
      spi_instruction_done <= 1'b0;
    end else begin
      spi_instruction_done <= idone;
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
      fl_en <= fl_go;
      fl_set <= is_set;
      fl_mask <= N_READY'(1) << rx_byte[3:0];
      if (fl_en) ready_flags <= fl_set ? ready_flags | fl_mask : ready_flags & ~fl_mask;
      if (err_go || rd_err) addr_err <= 1'b1;
      if (byte_done && state == ADDR_H) addr_h <= rx_byte;
      if (byte_done && state == ADDR_L) addr <= addr_new;
      if (byte_done && state == DATA) addr <= addr_inc;
    end
  always_ff @(posedge SCLK)
    if (!RESET_N) all_data_out <= '0;
    else if (wr_en)
      for (int i = 0; i < DEPTH; i++) if (32'(wr_addr) == i) all_data_out[i*8 +: 8] <= wr_data;
endmodule

// File: tb/tb_spi_regbank_burst.sv
// tb_spi_regbank_burst: scoreboard bench for the SPI register bank (both SPI_READBACK_EN builds)
module tb_spi_regbank_burst;
  localparam int DEPTH = 149;
  logic SCLK = 1'b0, RESET_N = 1'b0, SS = 1'b1, MOSI = 1'b0;
  logic MISO, spi_instruction_done, data_valid_out, addr_err;
  logic [DEPTH*8-1:0] all_data_out;
  logic [1:0] ready_flags;
  int checks = 0, errors = 0, dv_cnt = 0, id_cnt = 0;
  logic [7:0] mdl [DEPTH];
  logic [23:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [1:0] flags_m = 2'b00;

  spi_regbank_burst dut (
    .SCLK(SCLK),
    .RESET_N(RESET_N),
    .SS(SS),
    .MOSI(MOSI),
    .MISO(MISO),
    .all_data_out(all_data_out),
    .ready_flags(ready_flags),
    .spi_instruction_done(spi_instruction_done),
    .data_valid_out(data_valid_out),
    .addr_err(addr_err)
  );

  always #5 SCLK = ~SCLK;

  always @(negedge SCLK) begin
    if (data_valid_out === 1'b1) dv_cnt++;
    if (spi_instruction_done === 1'b1) id_cnt++;
  end

  function automatic int bank_diff();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (all_data_out[8*k +: 8] !== mdl[k]) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      @(negedge SCLK);
      r[i] = MISO;
      SS = 1'b0;
      MOSI = b[i];
    end
  endtask

  task automatic end_frame();
    @(negedge SCLK);
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge SCLK);
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    logic [7:0] r;
    logic [15:0] p;
    p = a;
    send_byte(8'h02, r);
    send_byte(a[15:8], r);
    send_byte(a[7:0], r);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = (i == 0) ? d0 : d1;
      if (int'(p) < DEPTH) begin
        wr_q.push_back({p, d});
        mdl[int'(p)] = d;
        p = (int'(p) == DEPTH - 1) ? 16'd0 : p + 16'd1;
      end
      send_byte(d, r);
    end
    end_frame();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) begin
      @(negedge SCLK);
      SS = 1'b0;
      MOSI = 1'($urandom);
    end
    @(negedge SCLK);
    checks++; if (all_data_out !== '0) begin errors++; $display("FAIL reset_bank got %0d nonzero bytes want 0", bank_diff()); end
    checks++; if (ready_flags !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", ready_flags); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
    checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid_out); end
    checks++; if (spi_instruction_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", spi_instruction_done); end
    RESET_N = 1'b1;
    SS = 1'b1;
    @(negedge SCLK);
  endtask

  task automatic test_burst_write();
    logic [7:0] r;
    dv_cnt = 0;
    id_cnt = 0;
    send_byte(8'h02, r);
    send_byte(8'h00, r);
    send_byte(8'h04, r);
    wr_q.push_back({16'd4, 8'hAA}); mdl[4] = 8'hAA;
    send_byte(8'hAA, r);
    wr_q.push_back({16'd5, 8'h55}); mdl[5] = 8'h55;
    send_byte(8'h55, r);
    @(negedge SCLK);
    checks++; if (data_valid_out !== 1'b1) begin errors++; $display("FAIL burst_dv_pulse got %b want 1", data_valid_out); end
    checks++; if (all_data_out[47:40] !== 8'h00) begin errors++; $display("FAIL burst_latency bank[5] got %h want 00", all_data_out[47:40]); end
    SS = 1'b1;
    repeat (2) @(negedge SCLK);
    while (wr_q.size() > 0) begin
      logic [23:0] e;
      e = wr_q.pop_front();
      checks++; if (all_data_out[8*int'(e[23:8]) +: 8] !== e[7:0]) begin errors++; $display("FAIL burst_bank[%0d] got %h want %h", e[23:8], all_data_out[8*int'(e[23:8]) +: 8], e[7:0]); end
    end
    checks++; if (id_cnt != 1) begin errors++; $display("FAIL burst_done_pulses got %0d want 1", id_cnt); end
    checks++; if (dv_cnt != 5) begin errors++; $display("FAIL burst_dv_pulses got %0d want 5", dv_cnt); end
  endtask

  task automatic test_wrap_err();
    mem_write(16'h0094, 8'h11, 8'h22, 2);
    while (wr_q.size() > 0) begin
      logic [23:0] e;
      e = wr_q.pop_front();
      checks++; if (all_data_out[8*int'(e[23:8]) +: 8] !== e[7:0]) begin errors++; $display("FAIL wrap_bank[%0d] got %h want %h", e[23:8], all_data_out[8*int'(e[23:8]) +: 8], e[7:0]); end
    end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL wrap_addr_err got %b want 0", addr_err); end
    mem_write(16'h0100, 8'h33, 8'h00, 1);
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL oob_bank got %0d changed bytes want 0", bank_diff()); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oob_addr_err got %b want 1", addr_err); end
  endtask

  task automatic test_readback();
    logic [7:0] r0, r1, r2, r3, r4;
    mem_write(16'h0002, 8'h3C, 8'hA5, 2);
    while (wr_q.size() > 0) begin
      logic [23:0] e;
      e = wr_q.pop_front();
      checks++; if (all_data_out[8*int'(e[23:8]) +: 8] !== e[7:0]) begin errors++; $display("FAIL preload_bank[%0d] got %h want %h", e[23:8], all_data_out[8*int'(e[23:8]) +: 8], e[7:0]); end
    end
    id_cnt = 0;
`ifdef SPI_READBACK_EN
    rd_q.push_back(8'h3C);
    rd_q.push_back(8'hA5);
`else
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h00);
`endif
    send_byte(8'h03, r0);
    send_byte(8'h00, r1);
    send_byte(8'h02, r2);
    send_byte(8'h00, r3);
    send_byte(8'h00, r4);
    end_frame();
    checks++; if ({r0, r1, r2} !== 24'h0) begin errors++; $display("FAIL read_hdr_miso got %h want 000000", {r0, r1, r2}); end
    begin
      logic [7:0] w;
      w = rd_q.pop_front();
      checks++; if (r3 !== w) begin errors++; $display("FAIL read_byte0 got %h want %h", r3, w); end
      w = rd_q.pop_front();
      checks++; if (r4 !== w) begin errors++; $display("FAIL read_byte1 got %h want %h", r4, w); end
    end
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL read_bank got %0d changed bytes want 0", bank_diff()); end
    checks++; if (id_cnt != 1) begin errors++; $display("FAIL read_done_pulses got %0d want 1", id_cnt); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL read_miso_idle got %b want 0", MISO); end
  endtask

  task automatic test_flags();
    logic [7:0] ops [4];
    logic [7:0] r;
    ops = '{8'h11, 8'h10, 8'h21, 8'h12};
    for (int i = 0; i < 4; i++) begin
      id_cnt = 0;
      send_byte(ops[i], r);
      end_frame();
      if (int'(ops[i][3:0]) < 2) begin
        if (ops[i][7:4] == 4'h1) flags_m[ops[i][0]] = 1'b1;
        if (ops[i][7:4] == 4'h2) flags_m[ops[i][0]] = 1'b0;
      end
      checks++; if (ready_flags !== flags_m) begin errors++; $display("FAIL flags_op_%h got %b want %b", ops[i], ready_flags, flags_m); end
      checks++; if (id_cnt != 1) begin errors++; $display("FAIL flags_done_%h got %0d want 1", ops[i], id_cnt); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] r, b;
    b = 8'hEE;
    send_byte(8'h02, r);
    send_byte(8'h00, r);
    send_byte(8'h06, r);
    for (int i = 7; i >= 4; i--) begin
      @(negedge SCLK);
      SS = 1'b0;
      MOSI = b[i];
    end
    end_frame();
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL abort_bank got %0d changed bytes want 0", bank_diff()); end
    mem_write(16'h0000, 8'h77, 8'h00, 1);
    while (wr_q.size() > 0) begin
      logic [23:0] e;
      e = wr_q.pop_front();
      checks++; if (all_data_out[8*int'(e[23:8]) +: 8] !== e[7:0]) begin errors++; $display("FAIL abort_next_bank[%0d] got %h want %h", e[23:8], all_data_out[8*int'(e[23:8]) +: 8], e[7:0]); end
    end
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL abort_next_all got %0d differing bytes want 0", bank_diff()); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] r;
    send_byte(8'h02, r);
    send_byte(8'h00, r);
    send_byte(8'h10, r);
    send_byte(8'hC3, r);
    for (int i = 0; i < 3; i++) begin
      @(negedge SCLK);
      MOSI = 1'($urandom);
    end
    @(negedge SCLK);
    RESET_N = 1'b0;
    repeat (2) begin
      @(negedge SCLK);
      MOSI = 1'($urandom);
    end
    RESET_N = 1'b1;
    SS = 1'b1;
    @(negedge SCLK);
    for (int k = 0; k < DEPTH; k++) mdl[k] = 8'h00;
    flags_m = 2'b00;
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL midreset_bank got %0d nonzero bytes want 0", bank_diff()); end
    checks++; if (ready_flags !== 2'b00) begin errors++; $display("FAIL midreset_flags got %b want 00", ready_flags); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL midreset_addr_err got %b want 0", addr_err); end
    mem_write(16'h0001, 8'h5A, 8'h00, 1);
    while (wr_q.size() > 0) begin
      logic [23:0] e;
      e = wr_q.pop_front();
      checks++; if (all_data_out[8*int'(e[23:8]) +: 8] !== e[7:0]) begin errors++; $display("FAIL midreset_next_bank[%0d] got %h want %h", e[23:8], all_data_out[8*int'(e[23:8]) +: 8], e[7:0]); end
    end
    checks++; if (bank_diff() != 0) begin errors++; $display("FAIL midreset_next_all got %0d differing bytes want 0", bank_diff()); end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mdl[k] = 8'h00;
    test_reset();
    test_burst_write();
    test_wrap_err();
    test_readback();
    test_flags();
    test_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
